// File: rtl/rb_seq.sv
// rb_seq: register-bank access sequencer; decodes instructions, runs a small ALU
// and drives the bank selects, write enable and write data.
module rb_seq #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   instr_in,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [3*AW-1:0] rs_out,
  output logic            rw_out,
  output logic [DW-1:0]   d_out,
  input  logic [DW-1:0]   a_in,
  input  logic [DW-1:0]   b_in,
  output logic            done,
  output logic [2:0]      flags_out,
  output logic            err_out
);
  typedef enum logic [1:0] {IDLE, EXEC, IMM, WB} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] ir_q, ir_d, d_q, d_d;
  logic [2:0]    flags_q, flags_d;
  logic          err_q, err_d;
  logic [DW:0]   alu;
  logic [3:0]    op;
  logic          xfer, alu_op;
  assign op          = ir_q[DW-1 -: 4];
  assign alu_op      = op != 4'h0 && op <= 4'h9;
  assign instr_ready = state_q != EXEC;
  assign xfer        = instr_valid && instr_ready;
  assign rs_out      = ir_q[3*AW-1:0];
  assign rw_out      = state_q == WB && op != 4'h0 && op <= 4'hA;
  assign done        = state_q == WB;
  assign d_out       = d_q;
  assign flags_out   = flags_q;
  assign err_out     = err_q;
  // Bit DW carries C: carry/borrow for ADD/SUB, the shifted-out bit for shifts.
  always_comb begin
    alu = '0;
    case (op)
      4'h1:    alu = {1'b0, a_in};
      4'h2:    alu = {1'b0, a_in} + {1'b0, b_in};
      4'h3:    alu = {1'b0, a_in} - {1'b0, b_in};
      4'h4:    alu = {1'b0, a_in & b_in};
      4'h5:    alu = {1'b0, a_in | b_in};
      4'h6:    alu = {1'b0, a_in ^ b_in};
      4'h7:    alu = {1'b0, ~a_in};
      4'h8:    alu = {a_in, 1'b0};
      4'h9:    alu = {a_in[0], 1'b0, a_in[DW-1:1]};
      default: alu = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    d_d     = d_q;
    flags_d = flags_q;
    err_d   = err_q;
    case (state_q)
      IDLE, WB: begin
        if (xfer) begin
          ir_d    = instr_in;
          state_d = instr_in[DW-1 -: 4] == 4'hA ? IMM : EXEC;
        end else if (state_q == WB) begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d = WB;
        d_d     = alu_op ? alu[DW-1:0] : d_q;
        flags_d = alu_op ? {alu[DW-1:0] == '0, alu[DW-1], alu[DW]} : flags_q;
        err_d   = err_q || op >= 4'hB;
      end
      IMM: begin
        d_d     = instr_valid ? instr_in : d_q;
        state_d = instr_valid ? WB : IMM;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      d_q     <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      d_q     <= d_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_rb_seq.sv
// tb_rb_seq: drives rb_seq against a behavioural register bank and scores each
// retired instruction against hand-derived expected write-back and flags.
module tb_rb_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr_in = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [11:0] rs_out;
  logic        rw_out;
  logic [15:0] d_out;
  logic [15:0] a_in, b_in;
  logic        done;
  logic [2:0]  flags_out;
  logic        err_out;

  rb_seq #(.DW(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rs_out(rs_out), .rw_out(rw_out), .d_out(d_out),
    .a_in(a_in), .b_in(b_in), .done(done), .flags_out(flags_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  logic [15:0] regs [16];
  initial for (int i = 0; i < 16; i++) regs[i] = '0;
  always @(posedge clk) if (rw_out) regs[rs_out[11:8]] <= d_out;
  assign a_in = regs[rs_out[7:4]];
  assign b_in = regs[rs_out[3:0]];

  typedef struct {
    logic [15:0] w;
    logic [15:0] imm;
    logic [15:0] d;
    logic [2:0]  fl;
  } vec_t;

  typedef struct {
    logic        we;
    logic [3:0]  rd;
    logic [15:0] d;
    logic [2:0]  fl;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock and score any retirement seen after the edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done act=1 exp=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("wb_cycle", cyc, e.due);
        chk("rw_out", {31'b0, rw_out}, {31'b0, e.we});
        if (e.we) begin
          chk("rd_sel", {28'b0, rs_out[11:8]}, {28'b0, e.rd});
          chk("d_out", {16'b0, d_out}, {16'b0, e.d});
        end
        chk("flags", {29'b0, flags_out}, {29'b0, e.fl});
        chk("err", {31'b0, err_out}, {31'b0, e.err});
      end
    end else if (rw_out) begin
      checks++;
      errors++;
      $display("FAIL rw_without_done act=1 exp=0 (cycle %0d)", cyc);
    end
  endtask

  // Present one word; a pushed expectation retires lat cycles after the transfer edge.
  task automatic send(input logic [15:0] w, input logic push, input exp_t e, input int lat);
    int  k;
    int  n;
    logic ok;
    instr_in    = w;
    instr_valid = 1'b1;
    k = cyc + (instr_ready ? 1 : 2);
    if (push) begin
      e.due = k + lat;
      sb.push_back(e);
    end
    n = 0;
    ok = 1'b0;
    while (!ok) begin
      ok = instr_ready;
      step();
      n++;
      if (!ok && n > 20) begin
        checks++;
        errors++;
        $display("FAIL xfer_timeout act=%0d exp=%0d", n, 1);
        break;
      end
    end
    chk("xfer_cycle", cyc, k);
    instr_valid = 1'b0;
  endtask

  task automatic run(input logic [15:0] w, input logic [15:0] imm, input logic [15:0] d,
                     input logic [2:0] fl, input logic err);
    exp_t e;
    e = '{we: w[15:12] != 4'h0 && w[15:12] <= 4'hA, rd: w[11:8], d: d, fl: fl, err: err, due: 0};
    if (w[15:12] == 4'hA) begin
      send(w, 1'b0, e, 0);
      send(imm, 1'b1, e, 0);
    end else begin
      send(w, 1'b1, e, 1);
    end
  endtask

  vec_t vt [18];
  exp_t none;

  initial begin
    vt = '{
      '{16'hA300, 16'h1234, 16'h1234, 3'b000},
      '{16'hA100, 16'hFFFF, 16'hFFFF, 3'b000},
      '{16'hA200, 16'h0001, 16'h0001, 3'b000},
      '{16'h2412, 16'h0000, 16'h0000, 3'b101},
      '{16'h3542, 16'h0000, 16'hFFFF, 3'b011},
      '{16'h1630, 16'h0000, 16'h1234, 3'b000},
      '{16'h4731, 16'h0000, 16'h1234, 3'b000},
      '{16'h5832, 16'h0000, 16'h1235, 3'b000},
      '{16'h6913, 16'h0000, 16'hEDCB, 3'b010},
      '{16'h7A10, 16'h0000, 16'h0000, 3'b100},
      '{16'h8B10, 16'h0000, 16'hFFFE, 3'b011},
      '{16'h9C20, 16'h0000, 16'h0000, 3'b101},
      '{16'h8D30, 16'h0000, 16'h2468, 3'b000},
      '{16'h3533, 16'h0000, 16'h0000, 3'b100},
      '{16'h2333, 16'h0000, 16'h2468, 3'b000},
      '{16'h0000, 16'h0000, 16'h0000, 3'b000},
      '{16'h9E10, 16'h0000, 16'h7FFF, 3'b001},
      '{16'h2F31, 16'h0000, 16'h2467, 3'b001}
    };
    none = '{we: 1'b0, rd: 4'h0, d: 16'h0, fl: 3'b0, err: 1'b0, due: 0};
    step();
    step();
    chk("rst_rs", {20'b0, rs_out}, 32'h0);
    chk("rst_rw", {31'b0, rw_out}, 32'h0);
    chk("rst_d", {16'b0, d_out}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_flags", {29'b0, flags_out}, 32'h0);
    chk("rst_err", {31'b0, err_out}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", {31'b0, instr_ready}, 32'h1);

    for (int i = 0; i < 18; i++) run(vt[i].w, vt[i].imm, vt[i].d, vt[i].fl, 1'b0);

    run(16'hF000, 16'h0000, 16'h0000, 3'b001, 1'b1);
    run(16'h1620, 16'h0000, 16'h0001, 3'b000, 1'b1);

    send(16'hA700, 1'b0, none, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("imm_wait_ready", {31'b0, instr_ready}, 32'h1);
      chk("imm_wait_rw", {31'b0, rw_out}, 32'h0);
    end
    begin
      exp_t e;
      e = '{we: 1'b1, rd: 4'h7, d: 16'hBEEF, fl: 3'b000, err: 1'b1, due: 0};
      send(16'hBEEF, 1'b1, e, 0);
    end

    send(16'h2932, 1'b0, none, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_rs", {20'b0, rs_out}, 32'h0);
    chk("arst_rw", {31'b0, rw_out}, 32'h0);
    chk("arst_d", {16'b0, d_out}, 32'h0);
    chk("arst_done", {31'b0, done}, 32'h0);
    chk("arst_flags", {29'b0, flags_out}, 32'h0);
    chk("arst_err", {31'b0, err_out}, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("no_write_after_reset", {16'b0, regs[9]}, 32'h0000EDCB);
    run(16'h1190, 16'h0000, 16'hEDCB, 3'b010, 1'b0);
    step();
    step();
    chk("sb_empty", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
